// File: rtl/tl_ul_mem_model_if.sv
// tl_ul_if: TileLink-UL A/D channel bundle between a master and the memory responder.
interface tl_ul_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int SRC_W  = 4,
    parameter int SINK_W = 2
);
    logic [2:0]        a_opcode_i;
    logic [2:0]        a_param_i;
    logic [2:0]        a_size_i;
    logic [SRC_W-1:0]  a_source_i;
    logic [ADDR_W-1:0] a_address_i;
    logic [7:0]        a_mask_i;
    logic [DATA_W-1:0] a_data_i;
    logic              a_valid_i;
    logic              a_ready_o;
    logic [2:0]        d_opcode_o;
    logic [1:0]        d_param_o;
    logic [2:0]        d_size_o;
    logic [SRC_W-1:0]  d_source_o;
    logic [SINK_W-1:0] d_sink_o;
    logic              d_denied_o;
    logic              d_corrupt_o;
    logic [DATA_W-1:0] d_data_o;
    logic              d_valid_o;
    logic              d_ready_i;

    modport master (
        output a_opcode_i, a_param_i, a_size_i, a_source_i, a_address_i, a_mask_i, a_data_i,
               a_valid_i, d_ready_i,
        input  a_ready_o, d_opcode_o, d_param_o, d_size_o, d_source_o, d_sink_o, d_denied_o,
               d_corrupt_o, d_data_o, d_valid_o
    );
    modport slave (
        input  a_opcode_i, a_param_i, a_size_i, a_source_i, a_address_i, a_mask_i, a_data_i,
               a_valid_i, d_ready_i,
        output a_ready_o, d_opcode_o, d_param_o, d_size_o, d_source_o, d_sink_o, d_denied_o,
               d_corrupt_o, d_data_o, d_valid_o
    );
endinterface

// File: rtl/tl_ul_mem_model.sv
// tl_ul_mem_model: TileLink-UL memory responder with configurable latency and in-order response queue.
module tl_ul_mem_model #(
    parameter int              ADDR_W    = 64,
    parameter int              DATA_W    = 64,
    parameter int              SRC_W     = 4,
    parameter int              SINK_W    = 2,
    parameter int              MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              LATENCY   = 2,
    parameter int              QDEPTH    = 4,
    localparam int             CW        = $clog2(QDEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    tl_ul_if.slave        tl,
    input  logic          stall_i,
    output logic [CW-1:0] outstanding_o,
    output logic [15:0]   err_count_o
);
    localparam int PW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
    localparam int LW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    localparam int IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;

    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [2:0]        q_op   [QDEPTH];
    logic [2:0]        q_size [QDEPTH];
    logic [SRC_W-1:0]  q_src  [QDEPTH];
    logic              q_den  [QDEPTH];
    logic [DATA_W-1:0] q_data [QDEPTH];
    logic [LW-1:0]     q_age  [QDEPTH];

    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] off;
    logic [IW-1:0]     idx;
    logic              is_get, is_put, legal, acc, ret, busy;
    logic              unused_bits;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        off         = tl.a_address_i - BASE_ADDR;
        idx         = off[IW+2:3];
        is_get      = tl.a_opcode_i == 3'd4;
        is_put      = tl.a_opcode_i == 3'd0 || tl.a_opcode_i == 3'd1;
        legal       = tl.a_address_i >= BASE_ADDR && (off >> 3) < ADDR_W'(MEM_WORDS)
                      && tl.a_size_i <= 3'd3 && (is_get || is_put);
        busy        = count != '0;
        tl.a_ready_o = count != CW'(QDEPTH) && !stall_i;
        acc         = tl.a_valid_i && tl.a_ready_o;
        tl.d_valid_o = busy && q_age[rptr] == '0;
        ret         = tl.d_valid_o && tl.d_ready_i;
        tl.d_opcode_o  = busy ? q_op[rptr] : 3'd0;
        tl.d_size_o    = busy ? q_size[rptr] : 3'd0;
        tl.d_source_o  = busy ? q_src[rptr] : '0;
        tl.d_denied_o  = busy && q_den[rptr];
        tl.d_corrupt_o = busy && q_den[rptr] && q_op[rptr][0];
        tl.d_data_o    = busy ? q_data[rptr] : '0;
        tl.d_param_o   = 2'd0;
        tl.d_sink_o    = '0;
        outstanding_o  = count;
        unused_bits    = ^{tl.a_param_i, off[2:0]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            err_count_o <= '0;
        end else begin
            if (acc) wptr <= inc(wptr);
            if (ret) rptr <= inc(rptr);
            count <= count + CW'(acc) - CW'(ret);
            if (acc && !legal && err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
        end
    end

    // Payload and store are not reset; an empty queue masks stale entries from the D outputs.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < QDEPTH; i++)
            if (q_age[i] != '0) q_age[i] <= q_age[i] - 1'b1;
        if (acc) begin
            q_op[wptr]   <= is_get ? 3'd1 : 3'd0;
            q_size[wptr] <= tl.a_size_i;
            q_src[wptr]  <= tl.a_source_i;
            q_den[wptr]  <= !legal;
            q_data[wptr] <= (is_get && legal) ? mem[idx] : '0;
            q_age[wptr]  <= LW'(LATENCY - 1);
        end
        if (acc && legal && is_put)
            for (int b = 0; b < 8; b++)
                if (tl.a_mask_i[b]) mem[idx][8*b +: 8] <= tl.a_data_i[8*b +: 8];
    end
endmodule

// File: tb/tb_tl_ul_mem_model.sv
// tb_tl_ul_mem_model: directed checks of the TileLink-UL memory responder with default parameters.
module tb_tl_ul_mem_model;
    localparam logic [2:0] PUTF = 3'd0, PUTP = 3'd1, GET = 3'd4;

    logic        clk = 0, rst_n = 1, stall = 0;
    logic [2:0]  outstanding;
    logic [15:0] err_count;
    int          vectors = 0, errs = 0;
    logic [2:0]  r_op;
    logic        r_den, r_cor;
    logic [63:0] r_data;
    logic [3:0]  r_src;

    tl_ul_if tl ();

    tl_ul_mem_model dut (
        .clk_i(clk), .rst_ni(rst_n), .tl(tl), .stall_i(stall),
        .outstanding_o(outstanding), .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [63:0] addr, input logic [7:0] mask,
                         input logic [63:0] data, input logic [3:0] src);
        tl.a_opcode_i  = op;
        tl.a_param_i   = 3'd0;
        tl.a_size_i    = 3'd3;
        tl.a_source_i  = src;
        tl.a_address_i = addr;
        tl.a_mask_i    = mask;
        tl.a_data_i    = data;
        tl.a_valid_i   = 1'b1;
    endtask

    task automatic tick();
        logic acc;
        acc = tl.a_valid_i && tl.a_ready_o;
        @(negedge clk);
        if (acc) tl.a_valid_i = 1'b0;
    endtask

    task automatic wait_d(input string tag);
        int n = 0;
        while (!tl.d_valid_o && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 64'(tl.d_valid_o), 64'd1);
        r_op   = tl.d_opcode_o;
        r_den  = tl.d_denied_o;
        r_cor  = tl.d_corrupt_o;
        r_data = tl.d_data_o;
        r_src  = tl.d_source_o;
    endtask

    task automatic xact(input logic [2:0] op, input logic [63:0] addr, input logic [7:0] mask,
                        input logic [63:0] data, input logic [3:0] src);
        int n = 0;
        drive(op, addr, mask, data, src);
        while (!tl.a_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        tick();
        wait_d("xact d_valid");
        tick();
    endtask

    initial begin
        tl.a_valid_i = 0; tl.d_ready_i = 1;
        tl.a_opcode_i = 0; tl.a_param_i = 0; tl.a_size_i = 0; tl.a_source_i = 0;
        tl.a_address_i = 0; tl.a_mask_i = 0; tl.a_data_i = 0;
        #1 rst_n = 0;
        #1;
        chk("rst outstanding", 64'(outstanding), 64'd0);
        chk("rst d_valid", 64'(tl.d_valid_o), 64'd0);
        chk("rst err_count", 64'(err_count), 64'd0);
        chk("rst d_data", tl.d_data_o, 64'd0);
        chk("rst a_ready", 64'(tl.a_ready_o), 64'd1);
        stall = 1;
        #1 chk("rst a_ready stalled", 64'(tl.a_ready_o), 64'd0);
        stall = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        drive(PUTF, 64'h40, 8'hFF, 64'h1122334455667788, 4'd0);
        @(negedge clk);
        chk("lat put early", 64'(tl.d_valid_o), 64'd0);
        drive(GET, 64'h40, 8'h00, 64'd0, 4'd3);
        @(negedge clk);
        tl.a_valid_i = 0;
        chk("lat put valid", 64'(tl.d_valid_o), 64'd1);
        chk("put opcode", 64'(tl.d_opcode_o), 64'd0);
        chk("put denied", 64'(tl.d_denied_o), 64'd0);
        chk("two outstanding", 64'(outstanding), 64'd2);
        @(negedge clk);
        chk("lat get valid", 64'(tl.d_valid_o), 64'd1);
        chk("get opcode", 64'(tl.d_opcode_o), 64'd1);
        chk("get data", tl.d_data_o, 64'h1122334455667788);
        chk("get source", 64'(tl.d_source_o), 64'd3);
        chk("get size", 64'(tl.d_size_o), 64'd3);
        @(negedge clk);
        chk("drained valid", 64'(tl.d_valid_o), 64'd0);
        chk("drained outstanding", 64'(outstanding), 64'd0);

        xact(PUTF, 64'h40, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 4'd1);
        xact(PUTP, 64'h40, 8'h0F, 64'd0, 4'd2);
        chk("partial ack opcode", 64'(r_op), 64'd0);
        xact(GET, 64'h40, 8'h00, 64'd0, 4'd4);
        chk("partial data", r_data, 64'hFFFFFFFF00000000);

        xact(GET, 64'h2000, 8'h00, 64'd0, 4'd5);
        chk("oob opcode", 64'(r_op), 64'd1);
        chk("oob denied", 64'(r_den), 64'd1);
        chk("oob corrupt", 64'(r_cor), 64'd1);
        chk("oob data", r_data, 64'd0);
        chk("oob err_count", 64'(err_count), 64'd1);
        xact(3'd6, 64'h40, 8'hFF, 64'd0, 4'd6);
        chk("bad op opcode", 64'(r_op), 64'd0);
        chk("bad op denied", 64'(r_den), 64'd1);
        chk("bad op corrupt", 64'(r_cor), 64'd0);
        chk("bad op err_count", 64'(err_count), 64'd2);
        xact(GET, 64'h40, 8'h00, 64'd0, 4'd7);
        chk("bad op no write", r_data, 64'hFFFFFFFF00000000);
        xact(GET, 64'h1FF8, 8'h00, 64'd0, 4'd8);
        chk("last word denied", 64'(r_den), 64'd0);
        chk("last word opcode", 64'(r_op), 64'd1);

        tl.d_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            drive(GET, 64'h40, 8'h00, 64'd0, 4'(i));
            @(negedge clk);
        end
        chk("full a_ready", 64'(tl.a_ready_o), 64'd0);
        chk("full outstanding", 64'(outstanding), 64'd4);
        drive(GET, 64'h40, 8'h00, 64'd0, 4'd4);
        @(negedge clk);
        chk("full hold a_ready", 64'(tl.a_ready_o), 64'd0);
        chk("full hold outstanding", 64'(outstanding), 64'd4);
        chk("full head source", 64'(tl.d_source_o), 64'd0);
        tl.d_ready_i = 1;
        for (int s = 0; s < 5; s++) begin
            wait_d("drain d_valid");
            chk("drain order", 64'(r_src), 64'(s));
            tick();
        end
        chk("drain outstanding", 64'(outstanding), 64'd0);
        chk("drain a_ready", 64'(tl.a_ready_o), 64'd1);

        stall = 1;
        drive(GET, 64'h40, 8'h00, 64'd0, 4'd5);
        @(negedge clk);
        chk("stall a_ready", 64'(tl.a_ready_o), 64'd0);
        chk("stall no accept", 64'(outstanding), 64'd0);
        stall = 0;
        #1 chk("unstall a_ready", 64'(tl.a_ready_o), 64'd1);
        tick();
        chk("unstall accept", 64'(outstanding), 64'd1);
        wait_d("unstall d_valid");
        chk("unstall source", 64'(r_src), 64'd5);
        tick();

        tl.d_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            drive(GET, 64'h40, 8'h00, 64'd0, 4'(i));
            @(negedge clk);
        end
        tl.a_valid_i = 0;
        chk("pre-reset outstanding", 64'(outstanding), 64'd3);
        #2 rst_n = 0;
        #1;
        chk("mid reset d_valid", 64'(tl.d_valid_o), 64'd0);
        chk("mid reset outstanding", 64'(outstanding), 64'd0);
        chk("mid reset err_count", 64'(err_count), 64'd0);
        @(negedge clk);
        rst_n = 1;
        tl.d_ready_i = 1;
        xact(GET, 64'h40, 8'h00, 64'd0, 4'd9);
        chk("post reset data", r_data, 64'hFFFFFFFF00000000);
        chk("post reset source", 64'(r_src), 64'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
